// File: rtl/xgxs_tx_idle_sched.sv
// Single-lane XGXS transmit scheduler. It feeds the 8b/10b encoder one code
// group per cycle. Each slot goes either to a source byte or to the idle
// generator, which sends ||A|| every 16..31 idle slots and a pseudo-random
// ||K||/||R|| in the other idle slots. After reset it first sends a comma
// burst, and it marks illegal control codes as bad for the encoder.
module xgxs_tx_idle_sched #(
  parameter int unsigned SYNC_LEN  = 16,
  parameter logic [6:0]  PRBS_SEED = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_k,
  input  logic       in_err,
  output logic       in_ready,
  output logic [7:0] enc_data,
  output logic       enc_k,
  output logic       enc_bad,
  output logic       a_sent,
  output logic       sync_done
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [7:0] K28_5     = 8'hBC;  // ||K||
  localparam logic [7:0] K28_3     = 8'h7C;  // ||A||
  localparam logic [7:0] K28_0     = 8'h1C;  // ||R||
  localparam logic [7:0] K30_7     = 8'hFE;  // /E/
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);
  localparam logic [4:0] A_FIRST   = 5'd16;

  // The encoder can only encode these twelve control characters.
  function automatic logic is_legal_k(input logic [7:0] b);
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
      8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE: is_legal_k = 1'b1;
      default:                                  is_legal_k = 1'b0;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [7:0] sync_cnt_q, sync_cnt_d;
  logic [6:0] prbs_q, prbs_d;
  logic [4:0] a_cnt_q, a_cnt_d;
  logic [7:0] enc_data_q, enc_data_d;
  logic       enc_k_q, enc_k_d;
  logic       enc_bad_q, enc_bad_d;
  logic       in_ready_q, in_ready_d;
  logic       a_sent_q, a_sent_d;
  logic       sync_done_q, sync_done_d;

  // State register and all registered outputs. Reset is synchronous.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples the pre-edge values.
    if (rst) begin
      state_q     <= ST_SYNC;
      sync_cnt_q  <= '0;
      prbs_q      <= PRBS_SEED;
      a_cnt_q     <= A_FIRST;
      enc_data_q  <= K28_5;
      enc_k_q     <= 1'b1;
      enc_bad_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      a_sent_q    <= 1'b0;
      sync_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      prbs_q      <= prbs_d;
      a_cnt_q     <= a_cnt_d;
      enc_data_q  <= enc_data_d;
      enc_k_q     <= enc_k_d;
      enc_bad_q   <= enc_bad_d;
      in_ready_q  <= in_ready_d;
      a_sent_q    <= a_sent_d;
      sync_done_q <= sync_done_d;
    end
  end

  // Next state: leave SYNC after the comma burst, then track data vs idle slots.
  always_comb begin
    // NOTE: a default assignment on entry keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_SYNC: if (sync_cnt_q == SYNC_LAST) state_d = ST_IDLE;
      ST_IDLE: if (in_valid)                state_d = ST_DATA;
      ST_DATA: if (!in_valid)               state_d = ST_IDLE;
      default:                              state_d = ST_SYNC;
    endcase
  end

  // Slot content: comma burst, screened source byte, or idle code group.
  always_comb begin
    enc_data_d  = K28_5;
    enc_k_d     = 1'b1;
    enc_bad_d   = 1'b0;
    a_sent_d    = 1'b0;
    a_cnt_d     = a_cnt_q;
    sync_cnt_d  = sync_cnt_q;
    sync_done_d = sync_done_q;
    in_ready_d  = (state_d != ST_SYNC);
    // x^7 + x^6 + 1, Fibonacci form, free-running outside reset.
    prbs_d      = {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]};

    case (state_q)
      ST_SYNC: begin
        sync_cnt_d = sync_cnt_q + 8'd1;
        if (sync_cnt_q == SYNC_LAST) sync_done_d = 1'b1;
      end
      ST_IDLE, ST_DATA: begin
        if (in_valid) begin
          // Data slot: a_cnt holds, so a pending ||A|| waits for the next idle slot.
          if (in_err) begin
            enc_data_d = K30_7;
          end else if (in_k && !is_legal_k(in_data)) begin
            enc_data_d = in_data;
            enc_bad_d  = 1'b1;
          end else begin
            enc_data_d = in_data;
            enc_k_d    = in_k;
          end
        end else if (a_cnt_q == 5'd0) begin
          enc_data_d = K28_3;
          a_sent_d   = 1'b1;
          a_cnt_d    = A_FIRST + {1'b0, prbs_q[3:0]};
        end else begin
          enc_data_d = prbs_q[0] ? K28_5 : K28_0;
          a_cnt_d    = a_cnt_q - 5'd1;
        end
      end
      default: ;
    endcase
  end

  assign enc_data  = enc_data_q;
  assign enc_k     = enc_k_q;
  assign enc_bad   = enc_bad_q;
  assign in_ready  = in_ready_q;
  assign a_sent    = a_sent_q;
  assign sync_done = sync_done_q;

endmodule

// File: tb/tb_xgxs_tx_idle_sched.sv
// Self-checking bench for xgxs_tx_idle_sched. A behavioural model pushes
// the expected code group into a scoreboard queue when each stimulus cycle
// is driven. The entry is popped and compared once the DUT has registered it.
// Directed checks cover sync timing, ||A|| spacing, K/R balance, byte
// screening and reset in mid-stream.
module tb_xgxs_tx_idle_sched;

  localparam int unsigned SYNC_LEN  = 16;
  localparam logic [6:0]  PRBS_SEED = 7'h7F;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       bad;
    logic       rdy;
    logic       a;
    logic       sd;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_k;
  logic       in_err;
  logic       in_ready;
  logic [7:0] enc_data;
  logic       enc_k;
  logic       enc_bad;
  logic       a_sent;
  logic       sync_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  out_t obs;
  out_t sb_q[$];

  // model state
  int         m_state;
  int         m_cnt;
  logic [6:0] m_prbs;
  int         m_acnt;
  logic       m_sd;

  xgxs_tx_idle_sched #(.SYNC_LEN(SYNC_LEN), .PRBS_SEED(PRBS_SEED)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_k(in_k), .in_err(in_err), .in_ready(in_ready), .enc_data(enc_data),
    .enc_k(enc_k), .enc_bad(enc_bad), .a_sent(a_sent), .sync_done(sync_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, o, e, cyc);
    end
  endtask

  function automatic logic legal_k(input logic [7:0] b);
    return b inside {8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                     8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  endfunction

  // Reference model: what the scheduler should register at the coming edge.
  task automatic model(input logic r, input logic v, input logic [7:0] d,
                       input logic k, input logic e, output out_t x);
    int nst;
    x = '0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_prbs = PRBS_SEED; m_acnt = 16; m_sd = 1'b0;
      x.data = 8'hBC; x.k = 1'b1;
      return;
    end
    x.data = 8'hBC; x.k = 1'b1;
    nst = m_state;
    if (m_state == 0) begin
      if (m_cnt == SYNC_LEN - 1) begin nst = 1; m_sd = 1'b1; end
      m_cnt++;
    end else if (v) begin
      nst = 2;
      if (e)                      x.data = 8'hFE;
      else if (k && !legal_k(d)) begin x.data = d; x.bad = 1'b1; end
      else                        begin x.data = d; x.k = k; end
    end else begin
      nst = 1;
      if (m_acnt == 0) begin
        x.data = 8'h7C; x.a = 1'b1; m_acnt = 16 + int'(m_prbs[3:0]);
      end else begin
        x.data = m_prbs[0] ? 8'hBC : 8'h1C; m_acnt--;
      end
    end
    x.sd = m_sd;
    x.rdy = (nst != 0);
    m_prbs = {m_prbs[5:0], m_prbs[6] ^ m_prbs[5]};
    m_state = nst;
  endtask

  // One clock: drive inputs, push the expectation, compare after the edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic k, input logic e);
    out_t x;
    out_t exp_o;
    rst = r; in_valid = v; in_data = d; in_k = k; in_err = e;
    model(r, v, d, k, e, x);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    cyc = r ? 1 : cyc + 1;
    obs = {enc_data, enc_k, enc_bad, in_ready, a_sent, sync_done};
    exp_o = sb_q.pop_front();
    check("codegroup", 32'(obs), 32'(exp_o));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input logic k, input logic e);
    step(1'b0, 1'b1, d, k, e);
  endtask

  initial begin
    int nbad, first_a, last_a, gap, nbc, n1c, nother, nflag, na;
    logic [7:0] sbytes [4];
    logic       sk     [4];
    sbytes = '{8'hFB, 8'h55, 8'hAA, 8'hFD};
    sk     = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
    check("rst_data", 32'(obs.data), 32'hBC);
    check("rst_k", 32'(obs.k), 32'd1);
    check("rst_ready", 32'(obs.rdy), 32'd0);
    check("rst_sync_done", 32'(obs.sd), 32'd0);

    // Comma burst: BC with sync_done low for cycles 1..16, rise on 17
    nbad = 0;
    while (cyc < 16) begin
      idle();
      if (obs.data !== 8'hBC || obs.k !== 1'b1 || obs.sd !== 1'b0) nbad++;
    end
    check("sync_burst_bad_cycles", 32'(nbad), 32'd0);
    idle();
    check("sync_done_rise", 32'(obs.sd), 32'd1);
    check("ready_after_sync", 32'(obs.rdy), 32'd1);

    // First ||A|| at the 17th idle slot (cycle 34)
    first_a = 0;
    for (int i = 0; i < 60 && first_a == 0; i++) begin
      idle();
      if (obs.a === 1'b1) first_a = cyc;
    end
    check("first_a_cycle", 32'(first_a), 32'd34);

    // Long idle: A spacing, symbol set, K/R balance
    last_a = first_a; nbc = 0; n1c = 0; nother = 0; nflag = 0; na = 0;
    for (int i = 0; i < 2000; i++) begin
      idle();
      if (obs.bad !== 1'b0) nflag++;
      if (obs.a === 1'b1) begin
        gap = cyc - last_a;
        check("a_gap_17_32", 32'(gap >= 17 && gap <= 32), 32'd1);
        last_a = cyc;
        na++;
        if (obs.data !== 8'h7C) nother++;
      end else if (obs.data === 8'hBC) nbc++;
      else if (obs.data === 8'h1C) n1c++;
      else nother++;
    end
    check("idle_symbol_set", 32'(nother), 32'd0);
    check("idle_bad_flag", 32'(nflag), 32'd0);
    check("a_count_min", 32'(na >= 60), 32'd1);
    check("bc_ratio", 32'(nbc * 10 >= 4 * (nbc + n1c) && nbc * 10 <= 6 * (nbc + n1c)), 32'd1);
    check("r_ratio", 32'(n1c * 10 >= 4 * (nbc + n1c) && n1c * 10 <= 6 * (nbc + n1c)), 32'd1);

    // Back-to-back stream then idle resumes
    for (int i = 0; i < 4; i++) begin
      send(sbytes[i], sk[i], 1'b0);
      check("stream_data", 32'(obs.data), 32'(sbytes[i]));
      check("stream_k", 32'(obs.k), 32'(sk[i]));
      check("stream_ready", 32'(obs.rdy), 32'd1);
    end
    idle();
    check("idle_resume", 32'(obs.data inside {8'hBC, 8'h1C, 8'h7C}), 32'd1);

    // Illegal K code surrounded by good bytes
    send(8'h11, 1'b0, 1'b0);
    check("pre_bad_data", 32'(obs.data), 32'h11);
    send(8'h26, 1'b1, 1'b0);
    check("illegal_k_data", 32'(obs.data), 32'h26);
    check("illegal_k_k", 32'(obs.k), 32'd1);
    check("illegal_k_bad", 32'(obs.bad), 32'd1);
    send(8'h22, 1'b0, 1'b0);
    check("post_bad_data", 32'(obs.data), 32'h22);
    check("post_bad_flag", 32'(obs.bad), 32'd0);

    // Error replacement
    send(8'h33, 1'b0, 1'b1);
    check("err_data", 32'(obs.data), 32'hFE);
    check("err_k", 32'(obs.k), 32'd1);
    check("err_bad", 32'(obs.bad), 32'd0);
    idle();

    // Mixed traffic, including data that lands on a due ||A||
    for (int i = 0; i < 400; i++) begin
      step(1'b0, ($urandom_range(0, 2) == 0), 8'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    end

    // Reset mid-frame, then full SYNC again with valid held high
    send(8'h44, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    check("midrst_data", 32'(obs.data), 32'hBC);
    check("midrst_k", 32'(obs.k), 32'd1);
    check("midrst_ready", 32'(obs.rdy), 32'd0);
    check("midrst_sync_done", 32'(obs.sd), 32'd0);
    nbad = 0;
    while (cyc < 16) begin
      send(8'h66, 1'b0, 1'b0);
      if (obs.data !== 8'hBC || obs.sd !== 1'b0 || obs.rdy !== 1'b0) nbad++;
    end
    check("resync_bad_cycles", 32'(nbad), 32'd0);
    send(8'h66, 1'b0, 1'b0);
    check("resync_done", 32'(obs.sd), 32'd1);
    check("transition_ignores_valid", 32'(obs.data), 32'hBC);
    send(8'h77, 1'b0, 1'b0);
    check("first_byte_after_resync", 32'(obs.data), 32'h77);
    idle();

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
